// File: rtl/idu_bypass_mux_pkg.sv
// Shared constants and types for the IDU operand bypass network.
package idu_bypass_mux_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int RF_DEPTH_BIT     = 5;
    localparam int RF_DEPTH         = 1 << RF_DEPTH_BIT;
    localparam int SUPER_SCALAR_NUM = 2;
    localparam int PC_WIDTH         = 32;
    localparam int EXCEPTION_NUM    = 16;

    typedef enum logic [1:0] {
        SRC_RF_READ = 2'd0,
        SRC_WB      = 2'd1,
        SRC_LSU     = 2'd2,
        SRC_IEX     = 2'd3
    } byp_src_e;

    // Only stages whose load data is still in flight can cause a load-use stall.
    function automatic logic src_can_stall(input byp_src_e src);
        return (src == SRC_IEX) || (src == SRC_LSU);
    endfunction

endpackage

// File: rtl/idu_byp_operand_sel.sv
// One source operand: youngest-producer match, data select and load-use hazard flag.
module idu_byp_operand_sel
    import idu_bypass_mux_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int IW = RF_DEPTH_BIT,
    parameter int N  = SUPER_SCALAR_NUM
) (
    input  logic [IW-1:0] src_idx,
    input  logic          src_idx_vld,
    input  logic [DW-1:0] rf_rd_data,
    input  logic [DW-1:0] iex_data     [N],
    input  logic [DW-1:0] lsu_data     [N],
    input  logic [DW-1:0] wb_data      [N],
    input  logic [IW-1:0] iex_rd       [N],
    input  logic [IW-1:0] lsu_rd       [N],
    input  logic [IW-1:0] wb_rd        [N],
    input  logic          iex_rd_vld   [N],
    input  logic          lsu_rd_vld   [N],
    input  logic          wb_rd_vld    [N],
    input  logic          iex_pipe_vld [N],
    input  logic          lsu_pipe_vld [N],
    input  logic          wb_pipe_vld  [N],
    input  logic          iex_is_load  [N],
    input  logic          lsu_is_load  [N],
    output logic [DW-1:0] sel_data,
    output logic          hazard
);

    logic     src_ok;
    logic     iex_hit [N];
    logic     lsu_hit [N];
    logic     wb_hit  [N];
    byp_src_e sel_src;
    logic     sel_load;

    // x0 is hardwired to zero and never forwards.
    assign src_ok = src_idx_vld && (src_idx != '0);

    for (genvar gi = 0; gi < N; gi++) begin : g_hit
        assign iex_hit[gi] = src_ok && iex_pipe_vld[gi] && iex_rd_vld[gi] && (iex_rd[gi] == src_idx);
        assign lsu_hit[gi] = src_ok && lsu_pipe_vld[gi] && lsu_rd_vld[gi] && (lsu_rd[gi] == src_idx);
        assign wb_hit[gi]  = src_ok && wb_pipe_vld[gi]  && wb_rd_vld[gi]  && (wb_rd[gi]  == src_idx);
    end

    // Walk from oldest to youngest so the last hit (youngest producer) wins.
    always_comb begin
        sel_data = rf_rd_data;
        sel_src  = SRC_RF_READ;
        sel_load = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (wb_hit[i]) begin
                sel_data = wb_data[i];
                sel_src  = SRC_WB;
                sel_load = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (lsu_hit[i]) begin
                sel_data = lsu_data[i];
                sel_src  = SRC_LSU;
                sel_load = lsu_is_load[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (iex_hit[i]) begin
                sel_data = iex_data[i];
                sel_src  = SRC_IEX;
                sel_load = iex_is_load[i];
            end
        end
    end

    assign hazard = src_can_stall(sel_src) && sel_load;

endmodule

// File: rtl/idu_bypass_mux.sv
// Decode-stage operand forwarding for rs1/rs2 with load-use stall and ID/EX operand registers.
module idu_bypass_mux #(
    parameter int DATA_WIDTH       = idu_bypass_mux_pkg::DATA_WIDTH,
    parameter int RF_DEPTH_BIT     = idu_bypass_mux_pkg::RF_DEPTH_BIT,
    parameter int SUPER_SCALAR_NUM = idu_bypass_mux_pkg::SUPER_SCALAR_NUM
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   rf_idu_rs1_data,
    input  logic [DATA_WIDTH-1:0]   rf_idu_rs2_data,
    input  logic [DATA_WIDTH-1:0]   iex_idu_byp_data [SUPER_SCALAR_NUM],
    input  logic [DATA_WIDTH-1:0]   lsu_idu_byp_data [SUPER_SCALAR_NUM],
    input  logic [DATA_WIDTH-1:0]   rf_idu_byp_data  [SUPER_SCALAR_NUM],
    input  logic [RF_DEPTH_BIT-1:0] iex_idu_byp_rd   [SUPER_SCALAR_NUM],
    input  logic [RF_DEPTH_BIT-1:0] lsu_idu_byp_rd   [SUPER_SCALAR_NUM],
    input  logic [RF_DEPTH_BIT-1:0] rf_idu_byp_rd    [SUPER_SCALAR_NUM],
    input  logic                    iex_idu_rd_vld   [SUPER_SCALAR_NUM],
    input  logic                    lsu_idu_rd_vld   [SUPER_SCALAR_NUM],
    input  logic                    rf_idu_rd_vld    [SUPER_SCALAR_NUM],
    input  logic                    iex_idu_pipe_vld [SUPER_SCALAR_NUM],
    input  logic                    lsu_idu_pipe_vld [SUPER_SCALAR_NUM],
    input  logic                    rf_idu_pipe_vld  [SUPER_SCALAR_NUM],
    input  logic                    iex_idu_is_load  [SUPER_SCALAR_NUM],
    input  logic                    lsu_idu_is_load  [SUPER_SCALAR_NUM],
    input  logic [RF_DEPTH_BIT-1:0] inst_rs1_idx,
    input  logic [RF_DEPTH_BIT-1:0] inst_rs2_idx,
    input  logic                    inst_rs1_idx_vld,
    input  logic                    inst_rs2_idx_vld,
    output logic [DATA_WIDTH-1:0]   idu_iex_rs1_data,
    output logic [DATA_WIDTH-1:0]   idu_iex_rs2_data,
    output logic                    idu_dispatcher_stall_vld
);

    logic [DATA_WIDTH-1:0] sel_data [2];
    logic                  hazard   [2];
    logic [RF_DEPTH_BIT-1:0] src_idx     [2];
    logic                    src_idx_vld [2];
    logic [DATA_WIDTH-1:0]   rf_rd_data  [2];

    assign src_idx[0]     = inst_rs1_idx;
    assign src_idx[1]     = inst_rs2_idx;
    assign src_idx_vld[0] = inst_rs1_idx_vld;
    assign src_idx_vld[1] = inst_rs2_idx_vld;
    assign rf_rd_data[0]  = rf_idu_rs1_data;
    assign rf_rd_data[1]  = rf_idu_rs2_data;

    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        idu_byp_operand_sel #(
            .DW (DATA_WIDTH),
            .IW (RF_DEPTH_BIT),
            .N  (SUPER_SCALAR_NUM)
        ) u_sel (
            .src_idx      (src_idx[gi]),
            .src_idx_vld  (src_idx_vld[gi]),
            .rf_rd_data   (rf_rd_data[gi]),
            .iex_data     (iex_idu_byp_data),
            .lsu_data     (lsu_idu_byp_data),
            .wb_data      (rf_idu_byp_data),
            .iex_rd       (iex_idu_byp_rd),
            .lsu_rd       (lsu_idu_byp_rd),
            .wb_rd        (rf_idu_byp_rd),
            .iex_rd_vld   (iex_idu_rd_vld),
            .lsu_rd_vld   (lsu_idu_rd_vld),
            .wb_rd_vld    (rf_idu_rd_vld),
            .iex_pipe_vld (iex_idu_pipe_vld),
            .lsu_pipe_vld (lsu_idu_pipe_vld),
            .wb_pipe_vld  (rf_idu_pipe_vld),
            .iex_is_load  (iex_idu_is_load),
            .lsu_is_load  (lsu_idu_is_load),
            .sel_data     (sel_data[gi]),
            .hazard       (hazard[gi])
        );
    end

    assign idu_dispatcher_stall_vld = hazard[0] | hazard[1];

    // A stalled cycle sends a zero bubble into IEX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idu_iex_rs1_data <= '0;
            idu_iex_rs2_data <= '0;
        end else if (idu_dispatcher_stall_vld) begin
            idu_iex_rs1_data <= '0;
            idu_iex_rs2_data <= '0;
        end else begin
            idu_iex_rs1_data <= sel_data[0];
            idu_iex_rs2_data <= sel_data[1];
        end
    end

endmodule

// File: tb/tb_idu_bypass_mux.sv
// Directed bench for idu_bypass_mux: hand-computed operand selection, stall and reset checks.
module tb_idu_bypass_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rf_rs1, rf_rs2;
    logic [31:0] iex_data [2], lsu_data [2], wb_data [2];
    logic [4:0]  iex_rd [2], lsu_rd [2], wb_rd [2];
    logic        iex_rdv [2], lsu_rdv [2], wb_rdv [2];
    logic        iex_pv [2], lsu_pv [2], wb_pv [2];
    logic        iex_ld [2], lsu_ld [2];
    logic [4:0]  rs1, rs2;
    logic        rs1_v, rs2_v;
    logic [31:0] out_rs1, out_rs2;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idu_bypass_mux dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .rf_idu_rs1_data          (rf_rs1),
        .rf_idu_rs2_data          (rf_rs2),
        .iex_idu_byp_data         (iex_data),
        .lsu_idu_byp_data         (lsu_data),
        .rf_idu_byp_data          (wb_data),
        .iex_idu_byp_rd           (iex_rd),
        .lsu_idu_byp_rd           (lsu_rd),
        .rf_idu_byp_rd            (wb_rd),
        .iex_idu_rd_vld           (iex_rdv),
        .lsu_idu_rd_vld           (lsu_rdv),
        .rf_idu_rd_vld            (wb_rdv),
        .iex_idu_pipe_vld         (iex_pv),
        .lsu_idu_pipe_vld         (lsu_pv),
        .rf_idu_pipe_vld          (wb_pv),
        .iex_idu_is_load          (iex_ld),
        .lsu_idu_is_load          (lsu_ld),
        .inst_rs1_idx             (rs1),
        .inst_rs2_idx             (rs2),
        .inst_rs1_idx_vld         (rs1_v),
        .inst_rs2_idx_vld         (rs2_v),
        .idu_iex_rs1_data         (out_rs1),
        .idu_iex_rs2_data         (out_rs2),
        .idu_dispatcher_stall_vld (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All lanes valid, no loads, destinations on registers no test reads.
    task automatic defaults();
        rf_rs1 = 32'h1111_1111; rf_rs2 = 32'h2222_2222;
        iex_data[0] = 32'hAAAA_AAAA; iex_data[1] = 32'hBBBB_BBBB;
        lsu_data[0] = 32'hCCCC_CCCC; lsu_data[1] = 32'hDDDD_DDDD;
        wb_data[0]  = 32'hEEEE_EEEE; wb_data[1]  = 32'hFFFF_FFFF;
        iex_rd[0] = 5'd10; iex_rd[1] = 5'd11;
        lsu_rd[0] = 5'd12; lsu_rd[1] = 5'd13;
        wb_rd[0]  = 5'd14; wb_rd[1]  = 5'd15;
        for (int i = 0; i < 2; i++) begin
            iex_rdv[i] = 1'b1; lsu_rdv[i] = 1'b1; wb_rdv[i] = 1'b1;
            iex_pv[i]  = 1'b1; lsu_pv[i]  = 1'b1; wb_pv[i]  = 1'b1;
            iex_ld[i]  = 1'b0; lsu_ld[i]  = 1'b0;
        end
        rs1 = 5'd20; rs2 = 5'd21; rs1_v = 1'b1; rs2_v = 1'b1;
    endtask

    // Check stall combinationally, then the registered operands one edge later.
    task automatic step(input string tag, input logic exp_stall,
                        input logic [31:0] exp_rs1, input logic [31:0] exp_rs2);
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        chk({tag, "_rs1"}, out_rs1, exp_rs1);
        chk({tag, "_rs2"}, out_rs2, exp_rs2);
        $display("step %s stall=%0b rs1=%h rs2=%h", tag, stall, out_rs1, out_rs2);
        @(negedge clk);
    endtask

    initial begin
        defaults();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_rs1", out_rs1, 32'h0);
        chk("reset_rs2", out_rs2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Every lane targets r3: youngest IEX lane wins.
        defaults();
        iex_rd = '{5'd3, 5'd3}; lsu_rd = '{5'd3, 5'd3}; wb_rd = '{5'd3, 5'd3};
        rs1 = 5'd3; rs2 = 5'd3;
        step("all_match", 1'b0, 32'hBBBB_BBBB, 32'hBBBB_BBBB);

        // Matching LSU[1] load stalls and bubbles the outputs.
        defaults();
        iex_rdv = '{1'b0, 1'b0};
        lsu_rd[1] = 5'd3; lsu_ld[1] = 1'b1; wb_rd[1] = 5'd4;
        rs1 = 5'd3; rs2 = 5'd4;
        step("lsu_load", 1'b1, 32'h0, 32'h0);

        // Disqualified producers fall back to register-file data.
        defaults();
        iex_rd = '{5'd5, 5'd4}; iex_rdv = '{1'b0, 1'b0};
        lsu_rd[0] = 5'd6; lsu_ld[0] = 1'b1;
        lsu_rd[1] = 5'd3; lsu_pv[1] = 1'b0;
        wb_rd[0] = 5'd3; wb_rdv[0] = 1'b0;
        wb_rd[1] = 5'd4; wb_pv[1] = 1'b0;
        rs1 = 5'd3; rs2 = 5'd4;
        step("no_match", 1'b0, 32'h1111_1111, 32'h2222_2222);

        // Younger non-load IEX[1] shadows an older LSU[0] load.
        defaults();
        lsu_rd[0] = 5'd3; lsu_ld[0] = 1'b1; iex_rd[1] = 5'd3;
        rs1 = 5'd3; rs2 = 5'd8;
        step("iex_shadow", 1'b0, 32'hBBBB_BBBB, 32'h2222_2222);
        iex_ld[1] = 1'b1;
        step("iex_load", 1'b1, 32'h0, 32'h0);

        // rs2 unused: its matching load is ignored.
        defaults();
        iex_rd = '{5'd3, 5'd3}; lsu_rd[1] = 5'd4; lsu_ld[1] = 1'b1;
        rs1 = 5'd3; rs2 = 5'd4; rs2_v = 1'b0;
        step("rs2_unused", 1'b0, 32'hBBBB_BBBB, 32'h2222_2222);

        // Single-lane priority points.
        defaults();
        iex_rd[0] = 5'd3; lsu_rd[1] = 5'd3; rs1 = 5'd3;
        lsu_rd[0] = 5'd7; wb_rd = '{5'd7, 5'd7}; rs2 = 5'd7;
        step("iex0_lsu0", 1'b0, 32'hAAAA_AAAA, 32'hCCCC_CCCC);

        defaults();
        wb_rd = '{5'd9, 5'd9}; rs1 = 5'd9;
        wb_rd[0] = 5'd9; rs2 = 5'd14;
        step("wb_prio", 1'b0, 32'hFFFF_FFFF, 32'h2222_2222);

        defaults();
        wb_rd[0] = 5'd9; wb_rd[1] = 5'd1; rs1 = 5'd9;
        lsu_rd[1] = 5'd2; rs2 = 5'd2;
        step("wb0_lsu1", 1'b0, 32'hEEEE_EEEE, 32'hDDDD_DDDD);

        // RF-stage match never stalls even with a non-matching load in LSU.
        defaults();
        wb_rd[1] = 5'd3; lsu_ld = '{1'b1, 1'b1}; iex_ld = '{1'b1, 1'b1};
        rs1 = 5'd3; rs2 = 5'd3;
        step("wb_no_stall", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // x0 never forwards; X on unused candidate data stays out.
        defaults();
        iex_rd = '{5'd0, 5'd0}; rs1 = 5'd0;
        lsu_data[1] = 'x; rs2 = 5'd5;
        step("x0_xdata", 1'b0, 32'h1111_1111, 32'h2222_2222);

        // Asynchronous reset mid-cycle; stall still tracks inputs.
        defaults();
        iex_rd[1] = 5'd3; rs1 = 5'd3;
        step("pre_reset", 1'b0, 32'hBBBB_BBBB, 32'h2222_2222);
        #2;
        rst_n = 1'b0;
        iex_ld[1] = 1'b1;
        #1;
        chk("async_rst_rs1", out_rs1, 32'h0);
        chk("async_rst_rs2", out_rs2, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd1);
        $display("step async_reset rs1=%h rs2=%h stall=%0b", out_rs1, out_rs2, stall);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
